// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the pending-write entry.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned WIDTH      = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WIDTH-1:0]      data;
  } wr_entry_t;

endpackage

// File: rtl/reg_write_port_if.sv
// Writeback request handshake between the pipeline (master) and the write port (slave).
interface reg_write_port_if;
  import regfile_pkg::*;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/decoder32.sv
// 5-to-32 one-hot decoder with enable; all-zero output when disabled.
module decoder32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] dec
);

  assign dec = en ? (32'(1) << sel) : 32'(0);

endmodule

// File: rtl/reg_write_fifo.sv
// In-order pending-write FIFO; storage is exposed so the top can run the forwarding search.
module reg_write_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          ctrl_reset,
  input  logic                          push,
  input  wr_entry_t                     push_entry,
  input  logic                          pop,
  output wr_entry_t [DEPTH-1:0]         entries,
  output logic [$clog2(DEPTH)-1:0]      rd_ptr,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      entries <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/reg_write_port.sv
// Register-file write port: buffers writebacks, drains one per cycle as a registered
// one-hot enable + data, and forwards pending writes to readers.
module reg_write_port
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  reg_write_port_if.slave          wr,
  input  logic                     hold,
  output logic [NREGS-1:0]         we_onehot,
  output logic [WIDTH-1:0]         we_data,
  input  logic [REG_ADDR_W-1:0]    fwd_addr,
  output logic                     fwd_hit,
  output logic [WIDTH-1:0]         fwd_data,
  output logic [$clog2(DEPTH):0]   pend_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      rd_ptr;
  wr_entry_t             push_entry_c;
  wr_entry_t             head_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;
  logic [NREGS-1:0]      dec_c;

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign wr.wr_ready   = (pend_count < CNT_W'(DEPTH));
  assign accept_c      = wr.wr_valid & wr.wr_ready;
  assign push_c        = accept_c & (wr.wr_addr != '0);
  assign pop_c         = (pend_count != '0) & ~hold;
  assign push_entry_c  = {wr.wr_addr, wr.wr_data};
  assign head_c        = entries[rd_ptr];

  reg_write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (pend_count)
  );

  decoder32 u_dec (
    .en  (pop_c),
    .sel (head_c.addr),
    .dec (dec_c)
  );

  // Output stage; bit 0 is masked so register 0 can never be written.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      we_onehot <= '0;
      we_data   <= '0;
    end else begin
      we_onehot <= dec_c & ~NREGS'(1);
      if (pop_c) begin
        we_data <= head_c.data;
      end
    end
  end

  // Scan oldest to youngest so the youngest match wins; output stage is lowest priority.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (we_onehot[fwd_addr]) begin
      fwd_hit  = 1'b1;
      fwd_data = we_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < pend_count) &&
          (entries[PTR_W'(rd_ptr + PTR_W'(k))].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[PTR_W'(rd_ptr + PTR_W'(k))].data;
      end
    end
    if (fwd_addr == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

endmodule
